// File: rtl/collapsering_harvester.sv
// collapsering_harvester: sequences the collapsing-ring oscillator (start,
// trims, clkmux), counts synchronized ring edges over a fixed window, reduces
// each trial to its edge-count parity and packs the bits into words offered
// on a valid/ready interface.
// Optional feature macro: RANDSACK_VON_NEUMANN_EN (von Neumann debiasing of
// trial-bit pairs). Default build shifts every trial bit in raw.
module collapsering_harvester #(
    parameter int TRIM_BITS     = 28,
    parameter int WORD_BITS     = 32,
    parameter int IDLE_CYCLES   = 16,
    parameter int WINDOW_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [TRIM_BITS-1:0] trim_a_cfg,
    input  logic [TRIM_BITS-1:0] trim_b_cfg,
    input  logic [2:0]           clkmux_cfg,
    output logic                 ring_start,
    output logic [TRIM_BITS-1:0] ring_trim_a,
    output logic [TRIM_BITS-1:0] ring_trim_b,
    output logic [2:0]           ring_clkmux,
    input  logic                 ring_clk,
    output logic [WORD_BITS-1:0] rnd_data,
    output logic                 rnd_valid,
    input  logic                 rnd_ready,
    output logic [15:0]          last_count,
    output logic                 busy
);

    localparam int CNT_W = $clog2(WORD_BITS + 1);
    localparam logic [31:0]      ARM_LAST    = 32'(IDLE_CYCLES - 1);
    localparam logic [31:0]      RUN_LAST    = 32'(WINDOW_CYCLES - 1);
    localparam logic [31:0]      SETTLE_LAST = 32'd2;
    localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(WORD_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_RUN, S_SETTLE, S_COLLECT, S_OUTPUT
    } state_t;

    state_t             state, next_state;
    logic [31:0]        timer;
    logic               sync1, sync2, sync3;
    logic               ring_edge;
    logic [15:0]        edge_cnt;
    logic [WORD_BITS-1:0] shreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic               trial_bit;
    logic               keep;
    logic               kept_bit;
    logic               word_done;
    logic               abort;

    assign ring_edge = sync2 & ~sync3;
    assign trial_bit = edge_cnt[0];
    assign word_done = keep && (bit_cnt == LAST_BIT);
    assign abort     = !enable && (state == S_ARM || state == S_RUN || state == S_SETTLE);
    assign rnd_data  = shreg;
    assign busy      = (state != S_IDLE);

`ifdef RANDSACK_VON_NEUMANN_EN
    logic have_first, first_bit;

    // Pair 10 keeps 1 and pair 01 keeps 0, so the kept bit is always the first.
    assign keep     = have_first && (first_bit != trial_bit);
    assign kept_bit = first_bit;

    // Holds the first bit of the pending pair; an abort throws it away.
    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            have_first <= 1'b0;
            first_bit  <= 1'b0;
        end else if (state == S_COLLECT) begin
            have_first <= ~have_first;
            if (!have_first) first_bit <= trial_bit;
        end
    end
`else
    assign keep     = 1'b1;
    assign kept_bit = trial_bit;
`endif

    // Next-state decode for the trial sequencer.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (enable) next_state = S_ARM;
            S_ARM:     if (!enable) next_state = S_IDLE;
                       else if (timer == ARM_LAST) next_state = S_RUN;
            S_RUN:     if (!enable) next_state = S_IDLE;
                       else if (timer == RUN_LAST) next_state = S_SETTLE;
            S_SETTLE:  if (!enable) next_state = S_IDLE;
                       else if (timer == SETTLE_LAST) next_state = S_COLLECT;
            S_COLLECT: if (word_done) next_state = S_OUTPUT;
                       else next_state = enable ? S_ARM : S_IDLE;
            S_OUTPUT:  if (rnd_ready) next_state = enable ? S_ARM : S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // State register and per-state cycle timer (restarts on every transition).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            timer <= '0;
        end else begin
            state <= next_state;
            timer <= (next_state != state) ? '0 : timer + 32'd1;
        end
    end

    // Ring clock synchronizer and saturating edge counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync3    <= 1'b0;
            edge_cnt <= '0;
        end else begin
            sync1 <= ring_clk;
            sync2 <= sync1;
            sync3 <= sync2;
            if (state == S_ARM)
                edge_cnt <= '0;
            else if ((state == S_RUN || state == S_SETTLE) && ring_edge && edge_cnt != '1)
                edge_cnt <= edge_cnt + 16'd1;
        end
    end

    // Registered ring controls, bit packing and output handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ring_start  <= 1'b0;
            rnd_valid   <= 1'b0;
            ring_trim_a <= '0;
            ring_trim_b <= '0;
            ring_clkmux <= '0;
            shreg       <= '0;
            bit_cnt     <= '0;
            last_count  <= '0;
        end else begin
            ring_start <= (next_state == S_RUN);
            rnd_valid  <= (next_state == S_OUTPUT);
            if (next_state == S_ARM && state != S_ARM) begin
                ring_trim_a <= trim_a_cfg;
                ring_trim_b <= trim_b_cfg;
                ring_clkmux <= clkmux_cfg;
            end
            if (abort) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end else if (state == S_COLLECT) begin
                last_count <= edge_cnt;
                if (keep) begin
                    shreg   <= (shreg << 1) | WORD_BITS'(kept_bit);
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (state == S_OUTPUT && rnd_ready) begin
                bit_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_collapsering_harvester.sv
// Bench for collapsering_harvester: table of edge-count patterns, reset/timing
// sequences, hold/abort corner cases, randomized edge counts against a
// trial-list model, and a long-window instance for counter saturation.
module tb_collapsering_harvester;
    localparam int TB     = 28;
    localparam int WB     = 32;
    localparam int IC     = 16;
    localparam int WC     = 64;
    localparam int TRIAL  = IC + WC + 4;
    localparam int SAT_WC = 131100;   // one edge per 2 clocks -> ~65550 edges
`ifdef RANDSACK_VON_NEUMANN_EN
    localparam int NTR = 2 * WB;
`else
    localparam int NTR = WB;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, enable, ring_clk, rnd_ready;
    logic [TB-1:0] trim_a_cfg, trim_b_cfg;
    logic [2:0] clkmux_cfg;
    logic ring_start, rnd_valid, busy;
    logic [TB-1:0] ring_trim_a, ring_trim_b;
    logic [2:0] ring_clkmux;
    logic [WB-1:0] rnd_data;
    logic [15:0] last_count;

    collapsering_harvester #(.TRIM_BITS(TB), .WORD_BITS(WB), .IDLE_CYCLES(IC),
                             .WINDOW_CYCLES(WC)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .trim_a_cfg(trim_a_cfg),
        .trim_b_cfg(trim_b_cfg), .clkmux_cfg(clkmux_cfg), .ring_start(ring_start),
        .ring_trim_a(ring_trim_a), .ring_trim_b(ring_trim_b), .ring_clkmux(ring_clkmux),
        .ring_clk(ring_clk), .rnd_data(rnd_data), .rnd_valid(rnd_valid),
        .rnd_ready(rnd_ready), .last_count(last_count), .busy(busy));

    logic sat_en, sat_ready, sat_ring, sat_start, sat_valid, sat_busy;
    logic [TB-1:0] sat_ta, sat_tb;
    logic [2:0] sat_cm;
    logic [0:0] sat_data;
    logic [15:0] sat_last;
    bit sat_done = 1'b0;

    collapsering_harvester #(.TRIM_BITS(TB), .WORD_BITS(1), .IDLE_CYCLES(IC),
                             .WINDOW_CYCLES(SAT_WC)) u_sat (
        .clk(clk), .rst_n(rst_n), .enable(sat_en), .trim_a_cfg(trim_a_cfg),
        .trim_b_cfg(trim_b_cfg), .clkmux_cfg(clkmux_cfg), .ring_start(sat_start),
        .ring_trim_a(sat_ta), .ring_trim_b(sat_tb), .ring_clkmux(sat_cm),
        .ring_clk(sat_ring), .rnd_data(sat_data), .rnd_valid(sat_valid),
        .rnd_ready(sat_ready), .last_count(sat_last), .busy(sat_busy));

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Ring edge driver: each ring_start rise pops a planned edge count (or
    // picks a random one) and emits that many 4-clock-period pulses.
    int plan[$];
    int driven[$];
    int trial_starts = 0;
    initial begin
        int n;
        ring_clk = 1'b0;
        forever begin
            @(posedge ring_start);
            n = (plan.size() > 0) ? plan.pop_front() : int'($urandom_range(0, 13));
            driven.push_back(n);
            trial_starts++;
            for (int k = 0; k < n; k++) begin
                #7 ring_clk = 1'b1;
                #20 ring_clk = 1'b0;
                #13;
            end
        end
    end

    // Free-running fast ring for the saturation instance.
    initial begin
        sat_ring = 1'b0;
        #5;
        forever #10 sat_ring = ~sat_ring;
    end

    // Reference model: trial counts -> parity bits -> (optional pairing) -> word.
    int unsigned mdl_ptr = 0;
    bit mdl_have = 1'b0;
    bit mdl_first = 1'b0;

    task automatic model_reset();
        mdl_ptr = driven.size();
        mdl_have = 1'b0;
    endtask

    task automatic model_take(output logic [31:0] w, output int lc, output int used);
        int n;
        bit b;
        w = '0; lc = -1; used = 0;
        while (mdl_ptr < driven.size()) begin
            n = driven[mdl_ptr];
            mdl_ptr++;
            used++;
            lc = n;
            b = (n > 65535) ? 1'b1 : ((n % 2) == 1);
`ifdef RANDSACK_VON_NEUMANN_EN
            if (!mdl_have) begin
                mdl_have = 1'b1;
                mdl_first = b;
            end else begin
                mdl_have = 1'b0;
                if (mdl_first != b) w = {w[30:0], mdl_first};
            end
`else
            w = {w[30:0], b};
`endif
        end
    endtask

    task automatic wait_valid(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (rnd_valid) got = 1'b1;
        end
    endtask

    task automatic idle_and_drain();
        enable = 1'b0;
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        check("drain_idle", busy, 1'b0);
        repeat (70) @(negedge clk);
    endtask

    typedef struct {
        int c0;
        int c1;
        logic [31:0] exp_word;
        bit exp_valid;
    } vec_t;
    vec_t vecs[4];

    // Saturation: one trial on the long-window instance.
    initial begin
        bit seen, done;
        sat_en = 1'b0;
        sat_ready = 1'b0;
        wait (rst_n === 1'b1);
        @(posedge clk); #1 sat_en = 1'b1;
        seen = 1'b0; done = 1'b0;
        for (int i = 0; i < SAT_WC + IC + 100 && !done; i++) begin
            @(negedge clk);
            if (sat_start) seen = 1'b1;
            else if (seen) done = 1'b1;
        end
        check("sat_window_end", done, 1'b1);
        repeat (5) @(negedge clk);
        check("sat_last_count", sat_last, 16'hFFFF);
`ifndef RANDSACK_VON_NEUMANN_EN
        check("sat_trial_bit", {sat_valid, sat_data}, 2'b11);
`endif
        sat_en = 1'b0;
        sat_done = 1'b1;
    end

    initial begin
        logic [TB-1:0] ta0, tb0;
        logic [2:0] cm0;
        logic [31:0] w;
        int arm, hi, held, lc, used, words, s0;
        bit seen, fell, got;

`ifdef RANDSACK_VON_NEUMANN_EN
        vecs[0] = '{5, 5, 32'h00000000, 1'b0};
        vecs[1] = '{4, 5, 32'h00000000, 1'b1};
        vecs[2] = '{5, 4, 32'hFFFFFFFF, 1'b1};
        vecs[3] = '{2, 7, 32'h00000000, 1'b1};
`else
        vecs[0] = '{5, 5, 32'hFFFFFFFF, 1'b1};
        vecs[1] = '{4, 5, 32'h55555555, 1'b1};
        vecs[2] = '{5, 4, 32'hAAAAAAAA, 1'b1};
        vecs[3] = '{6, 0, 32'h00000000, 1'b1};
`endif

        // Reset held 3 cycles with enable high: every output stays 0.
        ta0 = TB'($urandom); tb0 = TB'($urandom); cm0 = 3'($urandom_range(1, 6));
        rst_n = 1'b0; enable = 1'b1; rnd_ready = 1'b0;
        trim_a_cfg = ta0; trim_b_cfg = tb0; clkmux_cfg = cm0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outputs", {ring_start, ring_trim_a, ring_trim_b, ring_clkmux,
                                    rnd_data, rnd_valid, last_count, busy}, '0);
        end
        @(posedge clk); #1 rst_n = 1'b1;

        // ARM length, window length, and cfg latching only on ARM entry.
        arm = 0; seen = 1'b0;
        for (int i = 0; i < IC + 50 && !seen; i++) begin
            @(negedge clk);
            if (ring_start) seen = 1'b1;
            else if (busy) arm++;
            if (arm == 5) begin
                trim_a_cfg = ~ta0; trim_b_cfg = ~tb0; clkmux_cfg = ~cm0;
            end
        end
        check("first_rise_seen", seen, 1'b1);
        check("arm_cycles", arm, IC);
        check("trims_latched", {ring_trim_a, ring_trim_b, ring_clkmux}, {ta0, tb0, cm0});
        hi = 1; fell = 1'b0;
        for (int i = 0; i < WC + 50 && !fell; i++) begin
            @(negedge clk);
            if (ring_start) hi++;
            else fell = 1'b1;
        end
        check("run_cycles", hi, WC);
        check("trims_held", {ring_trim_a, ring_trim_b, ring_clkmux}, {ta0, tb0, cm0});

        // Table of alternating edge-count patterns, rnd_ready held high.
        for (int v = 0; v < 4; v++) begin
            idle_and_drain();
            plan.delete();
            for (int t = 0; t < NTR; t++) plan.push_back((t % 2 == 0) ? vecs[v].c0 : vecs[v].c1);
            ta0 = TB'($urandom); cm0 = 3'($urandom);
            trim_a_cfg = ta0; clkmux_cfg = cm0;
            rnd_ready = 1'b1; enable = 1'b1;
            wait_valid((NTR + 4) * TRIAL, got);
            check($sformatf("vec%0d_valid", v), got, vecs[v].exp_valid);
            if (got) begin
                enable = 1'b0;
                check($sformatf("vec%0d_data", v), rnd_data, vecs[v].exp_word);
                check($sformatf("vec%0d_last_count", v), last_count, vecs[v].c1);
                check($sformatf("vec%0d_trim", v), {ring_trim_a, ring_clkmux}, {ta0, cm0});
                @(negedge clk);
                check($sformatf("vec%0d_accept", v), {rnd_valid, busy}, 2'b00);
            end
        end

        // Word held for 50 cycles with rnd_ready low and enable dropped.
        idle_and_drain();
        plan.delete();
        model_reset();
        for (int t = 0; t < NTR; t++) plan.push_back((t % 2 == 0) ? 5 : 4);
        rnd_ready = 1'b0; enable = 1'b1;
        wait_valid((NTR + 4) * TRIAL, got);
        check("hold_valid", got, 1'b1);
        enable = 1'b0;
        model_take(w, lc, used);
        held = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rnd_valid && rnd_data == w && !ring_start && busy) held++;
        end
        check("hold_cycles", held, 50);
        check("hold_last_count", last_count, lc);
        @(posedge clk); #1 rnd_ready = 1'b1;
        @(negedge clk);
        check("hold_accept_word", {rnd_valid, rnd_data}, {1'b1, w});
        @(negedge clk);
        check("hold_released", {rnd_valid, busy}, 2'b00);

        // Abort mid-RUN after 11 completed trials; next word is fresh bits only.
        idle_and_drain();
        plan.delete();
        for (int t = 0; t < 11; t++) plan.push_back((t % 2 == 0) ? 5 : 4);
        plan.push_back(8);
        s0 = trial_starts;
        rnd_ready = 1'b1; enable = 1'b1;
        for (int i = 0; i < 13 * TRIAL && trial_starts < s0 + 12; i++) @(negedge clk);
        check("abort_reached_trial12", trial_starts - s0, 12);
        repeat (30) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("abort_ring_start", {ring_start, busy}, 2'b00);
        check("abort_last_count", last_count, 5);
        repeat (80) @(negedge clk);
        model_reset();
        for (int t = 0; t < NTR; t++) plan.push_back((t % 2 == 0) ? 4 : 5);
        enable = 1'b1;
        wait_valid((NTR + 4) * TRIAL, got);
        check("fresh_valid", got, 1'b1);
        enable = 1'b0;
        model_take(w, lc, used);
        check("fresh_trials", used, NTR);
        check("fresh_word", rnd_data, w);
        @(negedge clk);
        check("fresh_accept", {rnd_valid, busy}, 2'b00);

        // Random edge counts and random backpressure against the model.
        idle_and_drain();
        plan.delete();
        model_reset();
        words = 0;
        enable = 1'b1;
        for (int i = 0; i < 60000 && words < 3; i++) begin
            @(posedge clk); #1 rnd_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (rnd_valid && rnd_ready) begin
                model_take(w, lc, used);
                check("rand_word", rnd_data, w);
                check("rand_last_count", last_count, lc);
                words++;
            end
        end
        check("rand_words", words, 3);
        enable = 1'b0;
        rnd_ready = 1'b0;

        for (int i = 0; i < 200000 && !sat_done; i++) @(negedge clk);
        check("sat_finished", sat_done, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
